// File: rtl/mem_ctrl.sv
// Single-port RAM controller: CPU word reads, full writes, and byte-enabled
// writes serviced as read-modify-write against a RAM with registered read data.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int LANE_W = DATA_W / 4;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, WR_ISSUE, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;

  // Enabled lanes come from the CPU word, the rest keep the RAM contents.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] wdata,
                                                    input logic [DATA_W-1:0] old,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] m;
    m = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
    return m;
  endfunction

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!req_we)              state_nxt = RD_ISSUE;
          else if (req_be == 4'hF)  state_nxt = WR_ISSUE;
          else if (req_be == 4'h0)  state_nxt = DONE;
          else                      state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_CAP;
      RD_CAP:   state_nxt = we_q ? WR_ISSUE : DONE;
      WR_ISSUE: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    ram_read  = (state == RD_ISSUE);
    ram_write = (state == WR_ISSUE);
    rsp_valid = (state == DONE);
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = word_q;
  assign rsp_rdata = rdata_q;

  // Request capture, RMW merge in RD_CAP, and the held completion word.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= req_we;
        be_q   <= req_be;
        addr_q <= req_addr;
        word_q <= req_wdata;
        if (req_we && (req_be == 4'h0)) rdata_q <= '0;
      end
      if (state == RD_CAP) begin
        if (we_q) word_q  <= merge_lanes(word_q, ram_rdata, be_q);
        else      rdata_q <= ram_rdata;
      end
      if (state == WR_ISSUE) rdata_q <= word_q;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural registered-read RAM, strobe monitor and a
// queue of expected completions (data, latency) checked as responses arrive.
module tb_mem_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [3:0]        req_be = 4'h0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_read, ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_read(ram_read),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_rd = 0, n_wr = 0, n_both = 0, n_rsp = 0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  always @(negedge clk) begin
    if (ram_read) begin n_rd <= n_rd + 1; rd_addr <= ram_addr; end
    if (ram_write) begin n_wr <= n_wr + 1; wr_addr <= ram_addr; wr_data <= ram_wdata; end
    if (ram_read && ram_write) n_both <= n_both + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  typedef struct {logic [DATA_W-1:0] data; int lat;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, output int acc, output int waits, output bit ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    ok = 1'b0; acc = 0; waits = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin acc = cyc; ok = 1'b1; break; end
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_be = ~be; req_addr = ~addr; req_wdata = ~wd;
  endtask

  task automatic wait_rsp(output int rc, output logic [DATA_W-1:0] d, output bit ok);
    ok = 1'b0; rc = 0; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rc = cyc; d = rsp_rdata; ok = 1'b1; break; end
    end
    #2;
  endtask

  task automatic test_reset();
    #1 clr_n = 1'b0;
    #2;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if ({ram_read, ram_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {ram_read, ram_write}); end
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_cmp++; if (ram_wdata !== '0) begin n_bad++; $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_read();
    int acc, waits, rc, r0, w0; bit ok, got; logic [DATA_W-1:0] d; exp_t e;
    mem[9'h010] = 32'hDEADBEEF;
    r0 = n_rd; w0 = n_wr;
    issue(1'b0, 4'hF, 9'h010, 32'h0, acc, waits, ok);
    exp_q.push_back('{data: 32'hDEADBEEF, lat: 3});
    wait_rsp(rc, d, got);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || waits != 0) begin n_bad++; $display("FAIL read_first_accept: got waits %0d want 0", waits); end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL read_rsp: got timeout want rsp_valid"); end
    n_cmp++; if (rc - acc != e.lat) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", rc - acc, e.lat); end
    n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL read_data: got %h want %h", d, e.data); end
    n_cmp++; if (n_rd - r0 != 1 || n_wr - w0 != 0) begin n_bad++; $display("FAIL read_strobes: got rd %0d wr %0d want 1 0", n_rd - r0, n_wr - w0); end
    n_cmp++; if (rd_addr !== 9'h010) begin n_bad++; $display("FAIL read_addr: got %h want 010", rd_addr); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL read_pulse: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_hold: got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_full_write();
    int acc, waits, rc, r0, w0; bit ok, got; logic [DATA_W-1:0] d; exp_t e;
    r0 = n_rd; w0 = n_wr;
    issue(1'b1, 4'hF, 9'h1FF, 32'h12345678, acc, waits, ok);
    exp_q.push_back('{data: 32'h12345678, lat: 2});
    wait_rsp(rc, d, got);
    e = exp_q.pop_front();
    n_cmp++; if (!got || !ok) begin n_bad++; $display("FAIL fwr_rsp: got timeout want rsp_valid"); end
    n_cmp++; if (rc - acc != e.lat) begin n_bad++; $display("FAIL fwr_latency: got %0d want %0d", rc - acc, e.lat); end
    n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL fwr_data: got %h want %h", d, e.data); end
    n_cmp++; if (n_rd - r0 != 0 || n_wr - w0 != 1) begin n_bad++; $display("FAIL fwr_strobes: got rd %0d wr %0d want 0 1", n_rd - r0, n_wr - w0); end
    n_cmp++; if (wr_addr !== 9'h1FF) begin n_bad++; $display("FAIL fwr_addr: got %h want 1ff", wr_addr); end
    n_cmp++; if (mem[9'h1FF] !== 32'h12345678) begin n_bad++; $display("FAIL fwr_ram: got %h want 12345678", mem[9'h1FF]); end
  endtask

  task automatic test_partial_write();
    int acc, waits, rc, r0, w0; bit ok, got; logic [DATA_W-1:0] d; exp_t e;
    mem[9'h020] = 32'hAABBCCDD;
    r0 = n_rd; w0 = n_wr;
    issue(1'b1, 4'b0101, 9'h020, 32'h11223344, acc, waits, ok);
    exp_q.push_back('{data: 32'hAA22CC44, lat: 4});
    wait_rsp(rc, d, got);
    e = exp_q.pop_front();
    n_cmp++; if (!got || !ok) begin n_bad++; $display("FAIL pwr_rsp: got timeout want rsp_valid"); end
    n_cmp++; if (rc - acc != e.lat) begin n_bad++; $display("FAIL pwr_latency: got %0d want %0d", rc - acc, e.lat); end
    n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL pwr_data: got %h want %h", d, e.data); end
    n_cmp++; if (n_rd - r0 != 1 || n_wr - w0 != 1) begin n_bad++; $display("FAIL pwr_strobes: got rd %0d wr %0d want 1 1", n_rd - r0, n_wr - w0); end
    n_cmp++; if (wr_data !== 32'hAA22CC44 || wr_addr !== 9'h020) begin n_bad++; $display("FAIL pwr_ram_write: got %h@%h want aa22cc44@020", wr_data, wr_addr); end
    n_cmp++; if (mem[9'h020] !== 32'hAA22CC44) begin n_bad++; $display("FAIL pwr_ram: got %h want aa22cc44", mem[9'h020]); end
  endtask

  task automatic test_be_zero();
    int acc, waits, rc, r0, w0; bit ok, got; logic [DATA_W-1:0] d; exp_t e;
    mem[9'h0A0] = 32'h5A5A5A5A;
    r0 = n_rd; w0 = n_wr;
    issue(1'b1, 4'h0, 9'h0A0, 32'hFFFFFFFF, acc, waits, ok);
    exp_q.push_back('{data: 32'h0, lat: 1});
    wait_rsp(rc, d, got);
    e = exp_q.pop_front();
    n_cmp++; if (!got || !ok) begin n_bad++; $display("FAIL be0_rsp: got timeout want rsp_valid"); end
    n_cmp++; if (rc - acc != e.lat) begin n_bad++; $display("FAIL be0_latency: got %0d want %0d", rc - acc, e.lat); end
    n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL be0_data: got %h want %h", d, e.data); end
    n_cmp++; if (n_rd - r0 != 0 || n_wr - w0 != 0) begin n_bad++; $display("FAIL be0_strobes: got rd %0d wr %0d want 0 0", n_rd - r0, n_wr - w0); end
    n_cmp++; if (mem[9'h0A0] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL be0_ram: got %h want 5a5a5a5a", mem[9'h0A0]); end
  endtask

  task automatic test_mid_reset();
    int acc, waits, w0, s0; bit ok;
    mem[9'h030] = 32'h55667788;
    w0 = n_wr; s0 = n_rsp;
    issue(1'b1, 4'b0011, 9'h030, 32'hFFFFFFFF, acc, waits, ok);
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({ram_read, ram_write} !== 2'b00) begin n_bad++; $display("FAIL mid_strobes: got %b want 00", {ram_read, ram_write}); end
    n_cmp++; if (rsp_rdata !== 32'h0 || ram_wdata !== 32'h0 || ram_addr !== '0) begin n_bad++; $display("FAIL mid_regs: got %h %h %h want 0 0 0", rsp_rdata, ram_wdata, ram_addr); end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    n_cmp++; if (n_wr != w0) begin n_bad++; $display("FAIL mid_no_write: got %0d writes want 0", n_wr - w0); end
    n_cmp++; if (n_rsp != s0) begin n_bad++; $display("FAIL mid_no_rsp: got %0d rsp want 0", n_rsp - s0); end
    n_cmp++; if (mem[9'h030] !== 32'h55667788) begin n_bad++; $display("FAIL mid_ram: got %h want 55667788", mem[9'h030]); end
  endtask

  task automatic test_back_to_back();
    int acc1 = 0, acc2 = 0, rc1 = 0, rc2 = 0; bit a1 = 0, a2 = 0, s1 = 0, s2 = 0;
    logic [DATA_W-1:0] d1 = '0, d2 = '0; exp_t e;
    mem[9'h040] = 32'hCAFEF00D;
    exp_q.push_back('{data: 32'hCAFEF00D, lat: 3});
    exp_q.push_back('{data: 32'h0BADC0DE, lat: 2});
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 9'h040; req_wdata = 32'h0;
    for (int i = 0; i < 20 && !a1; i++) begin
      if (req_ready) begin acc1 = cyc; a1 = 1'b1; end
      else @(negedge clk);
    end
    @(posedge clk); #1;
    req_we = 1'b1; req_be = 4'hF; req_addr = 9'h041; req_wdata = 32'h0BADC0DE;
    for (int i = 0; i < 30 && !s2; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (!s1) begin rc1 = cyc; d1 = rsp_rdata; s1 = 1'b1; end
        else begin rc2 = cyc; d2 = rsp_rdata; s2 = 1'b1; end
      end
      if (req_valid && req_ready && !a2) begin
        acc2 = cyc; a2 = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 9'h000; req_wdata = 32'hFFFFFFFF;
      end
    end
    req_valid = 1'b0;
    #2;
    e = exp_q.pop_front();
    n_cmp++; if (!s1 || d1 !== e.data) begin n_bad++; $display("FAIL b2b_read_data: got %h want %h", d1, e.data); end
    n_cmp++; if (rc1 - acc1 != e.lat) begin n_bad++; $display("FAIL b2b_read_latency: got %0d want %0d", rc1 - acc1, e.lat); end
    n_cmp++; if (!a2 || acc2 != rc1 + 1) begin n_bad++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc2, rc1 + 1); end
    e = exp_q.pop_front();
    n_cmp++; if (!s2 || d2 !== e.data) begin n_bad++; $display("FAIL b2b_write_data: got %h want %h", d2, e.data); end
    n_cmp++; if (rc2 - acc2 != e.lat) begin n_bad++; $display("FAIL b2b_write_latency: got %0d want %0d", rc2 - acc2, e.lat); end
    n_cmp++; if (mem[9'h041] !== 32'h0BADC0DE || mem[9'h040] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_ram: got %h %h want cafef00d 0badc0de", mem[9'h040], mem[9'h041]); end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_be_zero();
    test_mid_reset();
    test_back_to_back();
    n_cmp++; if (n_both != 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
